// File: rtl/aer_pkg.sv
// Shared types and helpers for the spike AER encoder.
// Optional feature macro: AER_TIMESTAMP_EN (adds the ts field to aer_event_t).
package aer_pkg;

    localparam int AER_DEFAULT_N    = 8;
    localparam int AER_DEFAULT_AW   = $clog2(AER_DEFAULT_N);
    localparam int AER_DEFAULT_TS_W = 16;
    // Widest spike vector the popcount helper accepts.
    localparam int AER_MAX_N        = 256;

    typedef struct packed {
        logic [AER_DEFAULT_AW-1:0]   addr;
`ifdef AER_TIMESTAMP_EN
        logic [AER_DEFAULT_TS_W-1:0] ts;
`endif
    } aer_event_t;

    // Number of set bits; callers zero-extend narrower vectors.
    function automatic int unsigned popcount(input logic [AER_MAX_N-1:0] vec);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < AER_MAX_N; i++) begin
            cnt = cnt + {31'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/spike_aer_encoder_if.sv
// AER event stream: valid/ready handshake carrying a channel address.
// Optional feature macro: AER_TIMESTAMP_EN (adds aer_ts).
interface spike_aer_encoder_if #(
    parameter int ADDR_W = 3
`ifdef AER_TIMESTAMP_EN
    , parameter int TS_W = 16
`endif
) ();

    logic              aer_valid;
    logic [ADDR_W-1:0] aer_addr;
    logic              aer_ready;
`ifdef AER_TIMESTAMP_EN
    logic [TS_W-1:0]   aer_ts;
`endif

    modport master (
        output aer_valid,
        output aer_addr,
`ifdef AER_TIMESTAMP_EN
        output aer_ts,
`endif
        input  aer_ready
    );

    modport slave (
        input  aer_valid,
        input  aer_addr,
`ifdef AER_TIMESTAMP_EN
        input  aer_ts,
`endif
        output aer_ready
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or above
// ptr, wrapping to index 0.
module rr_arbiter #(
    parameter int N_INPUTS = 8,
    parameter int ADDR_W   = $clog2(N_INPUTS)
) (
    input  logic [N_INPUTS-1:0] req,
    input  logic [ADDR_W-1:0]   ptr,
    output logic                grant_valid,
    output logic [ADDR_W-1:0]   grant_idx
);

    logic [ADDR_W:0]   idx_sum;
    logic [ADDR_W-1:0] idx;

    // Scan offsets from ptr upward; the first hit wins. ptr < N_INPUTS, so
    // one conditional subtract is enough to wrap.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx_sum     = '0;
        idx         = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            idx_sum = {1'b0, ptr} + (ADDR_W+1)'(k);
            if (idx_sum >= (ADDR_W+1)'(N_INPUTS)) begin
                idx_sum = idx_sum - (ADDR_W+1)'(N_INPUTS);
            end
            idx = idx_sum[ADDR_W-1:0];
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// Spike-to-AER encoder: buffers one pending bit per channel and serialises
// them through a round-robin arbiter into a valid/ready event stream.
// Spikes hitting an already-pending channel are dropped and counted.
// Optional feature macro: AER_TIMESTAMP_EN (cycle-counter timestamp on aer_ts).
module spike_aer_encoder
    import aer_pkg::*;
#(
    parameter int N_INPUTS = AER_DEFAULT_N,
    parameter int ADDR_W   = $clog2(N_INPUTS),
    parameter int DROP_W   = 16
`ifdef AER_TIMESTAMP_EN
    , parameter int TS_W   = 16
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_INPUTS-1:0] spike_in,
    spike_aer_encoder_if.master aer,
    output logic                pending_any,
    output logic [DROP_W-1:0]   drop_cnt,
    input  logic                drop_clr
);

    localparam logic [32:0] DROP_MAX = 33'((64'd1 << DROP_W) - 64'd1);

    logic [N_INPUTS-1:0]  pending;
    logic [ADDR_W-1:0]    rr_ptr;
    logic                 out_valid;
    logic [ADDR_W-1:0]    out_addr;
    logic                 grant_valid;
    logic [ADDR_W-1:0]    grant_idx;
    logic                 out_free;
    logic                 load;
    logic [N_INPUTS-1:0]  grant_onehot;
    logic [N_INPUTS-1:0]  drop_vec;
    logic [AER_MAX_N-1:0] drop_vec_ext;
    logic [32:0]          drop_sum;

`ifdef AER_TIMESTAMP_EN
    logic [TS_W-1:0]      ts_cnt;
    logic [TS_W-1:0]      out_ts;
`endif

    rr_arbiter #(
        .N_INPUTS (N_INPUTS),
        .ADDR_W   (ADDR_W)
    ) u_arb (
        .req         (pending),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Load decision and drop detection; a spike on the channel being granted
    // this edge re-arms it instead of counting as a drop.
    always_comb begin
        out_free     = !out_valid || aer.aer_ready;
        load         = out_free && grant_valid;
        grant_onehot = '0;
        if (load) begin
            grant_onehot[grant_idx] = 1'b1;
        end
        drop_vec     = spike_in & pending & ~grant_onehot;
        drop_vec_ext = '0;
        drop_vec_ext[N_INPUTS-1:0] = drop_vec;
        drop_sum     = 33'(drop_cnt) + 33'(popcount(drop_vec_ext));
    end

    // Pending bits and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            rr_ptr  <= '0;
        end else begin
            pending <= (pending & ~grant_onehot) | spike_in;
            if (load) begin
                rr_ptr <= (grant_idx == ADDR_W'(N_INPUTS - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    // Output register: reloads only when free, so a stalled event stays put.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
`ifdef AER_TIMESTAMP_EN
            out_ts    <= '0;
`endif
        end else if (out_free) begin
            out_valid <= grant_valid;
            if (grant_valid) begin
                out_addr <= grant_idx;
`ifdef AER_TIMESTAMP_EN
                out_ts   <= ts_cnt;
`endif
            end
        end
    end

    // Saturating drop counter; clear takes priority over a same-cycle drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_clr) begin
            drop_cnt <= '0;
        end else if (drop_sum > DROP_MAX) begin
            drop_cnt <= '1;
        end else begin
            drop_cnt <= drop_sum[DROP_W-1:0];
        end
    end

`ifdef AER_TIMESTAMP_EN
    // Free-running timestamp, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
        end
    end

    assign aer.aer_ts = out_ts;
`endif

    assign aer.aer_valid = out_valid;
    assign aer.aer_addr  = out_addr;
    assign pending_any   = |pending;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Testbench for spike_aer_encoder: directed scenarios followed by random
// traffic, every cycle compared against a behavioural event model.
// Optional feature macro: AER_TIMESTAMP_EN (also checks aer_ts).
module tb_spike_aer_encoder;
    import aer_pkg::*;

    localparam int N    = AER_DEFAULT_N;
    localparam int AW   = $clog2(N);
    localparam int DW   = 4;
    localparam int DMAX = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  spike_in = '0;
    logic          drop_clr = 1'b0;
    logic          pending_any;
    logic [DW-1:0] drop_cnt;

    spike_aer_encoder_if #(
        .ADDR_W (AW)
`ifdef AER_TIMESTAMP_EN
        , .TS_W (16)
`endif
    ) aer_bus ();

    spike_aer_encoder #(
        .N_INPUTS (N),
        .ADDR_W   (AW),
        .DROP_W   (DW)
`ifdef AER_TIMESTAMP_EN
        , .TS_W   (16)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .spike_in    (spike_in),
        .aer         (aer_bus),
        .pending_any (pending_any),
        .drop_cnt    (drop_cnt),
        .drop_clr    (drop_clr)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit          m_pend [N];
    int          m_ptr;
    bit          m_valid;
    int          m_addr;
    int          m_drop;
    int unsigned m_ts;
    int unsigned m_ts_out;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          acc_cnt [N];
    aer_event_t  acc_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic bit model_any();
        bit r;
        r = 1'b0;
        for (int i = 0; i < N; i++) r = r | m_pend[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_ptr    = 0;
        m_valid  = 1'b0;
        m_addr   = 0;
        m_drop   = 0;
        m_ts     = 0;
        m_ts_out = 0;
    endtask

    // One clock edge of the encoder's event-level behaviour.
    task automatic model_step(input logic [N-1:0] sp, input bit rdy, input bit clr);
        bit old_p [N];
        int g;
        int drops;
        old_p = m_pend;
        g     = -1;
        if (!m_valid || rdy) begin
            for (int off = 0; off < N; off++) begin
                int i;
                i = (m_ptr + off) % N;
                if (g < 0 && m_pend[i]) g = i;
            end
            if (g >= 0) begin
                m_valid   = 1'b1;
                m_addr    = g;
                m_pend[g] = 1'b0;
                m_ptr     = (g + 1) % N;
                m_ts_out  = m_ts;
            end else begin
                m_valid = 1'b0;
            end
        end
        drops = 0;
        for (int i = 0; i < N; i++) begin
            if (sp[i]) begin
                if (old_p[i] && i != g) drops++;
                m_pend[i] = 1'b1;
            end
        end
        if (clr) m_drop = 0;
        else m_drop = (m_drop + drops > DMAX) ? DMAX : m_drop + drops;
        m_ts = (m_ts + 1) & 32'hFFFF;
    endtask

    task automatic clear_acc();
        for (int i = 0; i < N; i++) acc_cnt[i] = 0;
        acc_q.delete();
    endtask

    // Called at a falling edge: drive, cross one rising edge, compare.
    task automatic cycle(input logic [N-1:0] sp, input bit rdy, input bit clr);
        aer_event_t ev;
        spike_in          = sp;
        aer_bus.aer_ready = rdy;
        drop_clr          = clr;
        if (aer_bus.aer_valid === 1'b1 && rdy) begin
            acc_cnt[aer_bus.aer_addr]++;
            ev.addr = aer_bus.aer_addr;
`ifdef AER_TIMESTAMP_EN
            ev.ts   = aer_bus.aer_ts;
`endif
            acc_q.push_back(ev);
        end
        @(posedge clk);
        model_step(sp, rdy, clr);
        @(negedge clk);
        check("valid", aer_bus.aer_valid, m_valid);
        if (m_valid) check("addr", aer_bus.aer_addr, m_addr);
        check("pending_any", pending_any, model_any());
        check("drop_cnt", drop_cnt, m_drop);
`ifdef AER_TIMESTAMP_EN
        if (m_valid) check("ts", aer_bus.aer_ts, m_ts_out);
`endif
    endtask

    // Called at a falling edge; outputs must drop without waiting for a clock.
    task automatic apply_reset();
        rst               = 1'b1;
        spike_in          = '0;
        aer_bus.aer_ready = 1'b0;
        drop_clr          = 1'b0;
        #2;
        check("rst_valid", aer_bus.aer_valid, 0);
        check("rst_addr", aer_bus.aer_addr, 0);
        check("rst_pending_any", pending_any, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int cnt0;
        int cnt7;
        logic [N-1:0] r_sp;

        aer_bus.aer_ready = 1'b0;
        model_reset();
        clear_acc();
        @(negedge clk);
        apply_reset();

        // Single spike on channel 5 at cycle 10
        for (int c = 0; c < 9; c++) cycle('0, 1'b1, 1'b0);
        cycle(8'h20, 1'b1, 1'b0);
        check("single_t1_valid", aer_bus.aer_valid, 0);
        check("single_t1_pending", pending_any, 1);
        cycle('0, 1'b1, 1'b0);
        check("single_t2_valid", aer_bus.aer_valid, 1);
        check("single_t2_addr", aer_bus.aer_addr, 5);
        cycle('0, 1'b1, 1'b0);
        check("single_t3_valid", aer_bus.aer_valid, 0);
        check("single_accepted", acc_cnt[5], 1);
        check("single_drop", drop_cnt, 0);

        // Burst on all channels from rr_ptr = 0
        @(negedge clk);
        apply_reset();
        cycle(8'hFF, 1'b1, 1'b0);
        check("burst_t1_valid", aer_bus.aer_valid, 0);
        for (int k = 0; k < N; k++) begin
            cycle('0, 1'b1, 1'b0);
            check("burst_valid", aer_bus.aer_valid, 1);
            check("burst_addr", aer_bus.aer_addr, k);
        end
        cycle('0, 1'b1, 1'b0);
        check("burst_end_valid", aer_bus.aer_valid, 0);
        check("burst_end_pending", pending_any, 0);

        // Backpressure with a repeated spike on channel 2
        cycle(8'h04, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0);
        cycle(8'h04, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0);
        cycle(8'h04, 1'b0, 1'b0);
        check("bp_valid", aer_bus.aer_valid, 1);
        check("bp_addr", aer_bus.aer_addr, 2);
        check("bp_pending", pending_any, 1);
        check("bp_drop", drop_cnt, 1);
        clear_acc();
        for (int c = 0; c < 4; c++) cycle('0, 1'b1, 1'b0);
        check("bp_events_ch2", acc_cnt[2], 2);
        check("bp_events_total", acc_q.size(), 2);
        cycle('0, 1'b0, 1'b1);
        check("bp_clear", drop_cnt, 0);

        // Round-robin fairness between channels 0 and 7
        clear_acc();
        for (int c = 0; c < 16; c++) cycle(8'h81, 1'b1, 1'b0);
        check("rr_events", acc_q.size(), 14);
        check("rr_first", acc_q[0].addr, 7);
        for (int i = 1; i < acc_q.size(); i++) begin
            check("rr_alternate", acc_q[i].addr != acc_q[i-1].addr, 1);
        end
        cnt0 = acc_cnt[0];
        cnt7 = acc_cnt[7];
        check("rr_cnt0", cnt0, 7);
        check("rr_cnt7", cnt7, 7);
        for (int c = 0; c < 3; c++) cycle('0, 1'b1, 1'b0);

        // Drop counter saturation and clear priority
        cycle('0, 1'b1, 1'b1);
        check("sat_cleared", drop_cnt, 0);
        for (int c = 0; c < 10; c++) cycle(8'h02, 1'b0, 1'b0);
        check("sat_partial", drop_cnt, 8);
        for (int c = 0; c < 14; c++) cycle(8'h02, 1'b0, 1'b0);
        check("sat_max", drop_cnt, 15);
        cycle(8'h02, 1'b0, 1'b0);
        cycle(8'h02, 1'b0, 1'b0);
        check("sat_hold", drop_cnt, 15);
        cycle(8'h02, 1'b0, 1'b1);
        check("sat_clr_wins", drop_cnt, 0);
        cycle(8'h02, 1'b0, 1'b0);
        check("sat_after_clr", drop_cnt, 1);
        cycle('0, 1'b0, 1'b1);

        // Reset with an event in flight and pending = 8'hA5
        @(negedge clk);
        apply_reset();
        cycle(8'h02, 1'b0, 1'b0);
        cycle(8'hA5, 1'b0, 1'b0);
        check("mid_valid", aer_bus.aer_valid, 1);
        check("mid_addr", aer_bus.aer_addr, 1);
        check("mid_pending", pending_any, 1);
        apply_reset();
        clear_acc();
        for (int c = 0; c < 4; c++) cycle('0, 1'b1, 1'b0);
        check("post_rst_valid", aer_bus.aer_valid, 0);
        check("post_rst_pending", pending_any, 0);
        check("post_rst_no_events", acc_q.size(), 0);
        cycle(8'h08, 1'b1, 1'b0);
        cycle('0, 1'b1, 1'b0);
        check("post_rst_addr", aer_bus.aer_addr, 3);
        check("post_rst_valid3", aer_bus.aer_valid, 1);
`ifdef AER_TIMESTAMP_EN
        check("post_rst_ts", aer_bus.aer_ts, 5);
`endif
        cycle('0, 1'b1, 1'b0);

        // Random traffic against the model
        for (int c = 0; c < 500; c++) begin
            r_sp = N'($urandom() & $urandom());
            cycle(r_sp, ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
        end
        for (int c = 0; c < 100; c++) begin
            r_sp = N'($urandom() & $urandom() & $urandom());
            cycle(r_sp, ($urandom_range(0, 3) == 0), 1'b0);
        end
        for (int c = 0; c < 12; c++) cycle('0, 1'b1, 1'b0);
        check("final_drain_valid", aer_bus.aer_valid, 0);
        check("final_drain_pending", pending_any, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
